// File: rtl/fetch.sv
// Instruction-fetch stage of the sm83 core: owns the PC, issues byte reads and
// hands one opcode byte at a time to decode. Optional macro: SM83_HALT_BUG_EN.
module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_rdata,
  output logic [7:0]  o_instr,
  output logic        o_is_instr16,
  output logic [15:0] o_instr_pc,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_dec_is_instr16,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_halt_bug,
  output logic [15:0] o_pc
);

  typedef logic [7:0] instr_t;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] drain_addr_q, drain_addr_d;
  instr_t      instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        is16_q, is16_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_step_s;

`ifdef SM83_HALT_BUG_EN
  logic halt_q, halt_d;

  // Halt-bug flag: armed by a pulse, consumed by the next completed fetch, cleared by redirect.
  always_comb begin
    if (i_redirect) begin
      halt_d = 1'b0;
    end else if (i_halt_bug) begin
      halt_d = 1'b1;
    end else if ((state_q == S_REQ) && i_mem_ack) begin
      halt_d = 1'b0;
    end else begin
      halt_d = halt_q;
    end
  end

  // Halt-bug flag register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign pc_step_s = halt_q ? 16'd0 : 16'd1;
`else
  logic unused_halt_bug;
  assign unused_halt_bug = i_halt_bug;
  assign pc_step_s       = 16'd1;
`endif

  // Next-state logic; a redirect always wins over the handshake and the ack.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    is16_d       = is16_q;
    valid_d      = valid_q;
    case (state_q)
      S_REQ: begin
        if (i_redirect) begin
          pc_d    = i_redirect_pc;
          valid_d = 1'b0;
          is16_d  = 1'b0;
          if (i_mem_ack) begin
            state_d = S_REQ;
          end else begin
            // The read in flight must still complete at its original address.
            drain_addr_d = pc_q;
            state_d      = S_DRAIN;
          end
        end else if (i_mem_ack) begin
          instr_d    = i_mem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + pc_step_s;
          valid_d    = 1'b1;
          state_d    = S_VALID;
        end else begin
          state_d = S_REQ;
        end
      end
      S_VALID: begin
        if (i_redirect) begin
          pc_d    = i_redirect_pc;
          valid_d = 1'b0;
          is16_d  = 1'b0;
          state_d = S_REQ;
        end else if (i_ready) begin
          is16_d  = i_dec_is_instr16;
          valid_d = 1'b0;
          state_d = S_REQ;
        end else begin
          state_d = S_VALID;
        end
      end
      S_DRAIN: begin
        if (i_redirect) begin
          pc_d = i_redirect_pc;
        end else begin
          pc_d = pc_q;
        end
        if (i_mem_ack) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= 16'h0000;
      instr_q      <= 8'h00;
      instr_pc_q   <= 16'h0000;
      is16_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      is16_q       <= is16_d;
      valid_q      <= valid_d;
    end
  end

  // Request is gated by reset so the port is quiet while reset is held.
  assign o_mem_req    = i_rst_n && (state_q != S_VALID);
  assign o_mem_addr   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign o_instr      = instr_q;
  assign o_is_instr16 = is16_q;
  assign o_instr_pc   = instr_pc_q;
  assign o_valid      = valid_q;
  assign o_pc         = pc_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: cycle table, directed corner sequences and a
// randomized run against a delivered-byte-stream reference model.
module tb_fetch;

  logic        i_clk;
  logic        i_rst_n;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack;
  logic [7:0]  i_mem_rdata;
  logic [7:0]  o_instr;
  logic        o_is_instr16;
  logic [15:0] o_instr_pc;
  logic        o_valid;
  logic        i_ready;
  logic        i_dec_is_instr16;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        i_halt_bug;
  logic [15:0] o_pc;

  fetch #(.RESET_PC(16'h0100)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .o_mem_req        (o_mem_req),
    .o_mem_addr       (o_mem_addr),
    .i_mem_ack        (i_mem_ack),
    .i_mem_rdata      (i_mem_rdata),
    .o_instr          (o_instr),
    .o_is_instr16     (o_is_instr16),
    .o_instr_pc       (o_instr_pc),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .i_dec_is_instr16 (i_dec_is_instr16),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .i_halt_bug       (i_halt_bug),
    .o_pc             (o_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ack;
    logic [7:0]  rdata;
    logic        ready;
    logic        dec16;
    logic        redir;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [7:0]  e_instr;
    logic        e_is16;
    logic [15:0] e_ipc;
    logic [15:0] e_pc;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  logic [7:0] mem [0:65535];
  int  n_cmp = 0;
  int  n_fail = 0;
  bit  mem_auto = 1'b0;
  bit  rand_wait = 1'b0;
  int  wcnt = 0;
  int  wtgt = 0;

  function automatic vec_t mk(logic ack, logic [7:0] rdata, logic ready, logic dec16,
                              logic redir, logic [15:0] rpc, logic e_req, logic [15:0] e_addr,
                              logic e_valid, logic [7:0] e_instr, logic e_is16,
                              logic [15:0] e_ipc, logic [15:0] e_pc);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready; v.dec16 = dec16;
    v.redir = redir; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_instr = e_instr; v.e_is16 = e_is16;
    v.e_ipc = e_ipc; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic mem_respond();
    if (o_mem_req) begin
      if (wcnt >= wtgt) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = mem[o_mem_addr];
        wcnt        = 0;
        wtgt        = rand_wait ? int'($urandom_range(3, 0)) : 0;
      end else begin
        i_mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      i_mem_ack = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
    if (mem_auto) mem_respond();
  endtask

  logic [15:0] ipcs [3];
  logic [7:0]  ins  [3];
  logic [15:0] exp_ipc [3];
  logic [7:0]  h_instr;
  logic [15:0] h_ipc, h_pc, exp_pc, prev_addr;
  logic        exp_is16, prev_req, prev_ack;
  int          got, ndel;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    // ack rdata rdy d16 rdr rpc | req addr valid instr is16 ipc pc
    vt[0]  = mk(1'b1, 8'h3E, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0100);
    vt[1]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h3E, 1'b0, 16'h0100, 16'h0101);
    vt[2]  = mk(1'b1, 8'hCB, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0101, 1'b0, 8'h3E, 1'b0, 16'h0100, 16'h0101);
    vt[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'hCB, 1'b0, 16'h0101, 16'h0102);
    vt[4]  = mk(1'b1, 8'h37, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0102, 1'b0, 8'hCB, 1'b1, 16'h0101, 16'h0102);
    vt[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h37, 1'b1, 16'h0102, 16'h0103);
    vt[6]  = mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h37, 1'b1, 16'h0102, 16'h0103);
    vt[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h37, 1'b1, 16'h0102, 16'h0103);
    vt[8]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b1, 16'h0103, 1'b0, 8'h37, 1'b0, 16'h0102, 16'h0103);
    vt[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0103, 1'b0, 8'h37, 1'b0, 16'h0102, 16'h1234);
    vt[10] = mk(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0103, 1'b0, 8'h37, 1'b0, 16'h0102, 16'h1234);
    vt[11] = mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 8'h37, 1'b0, 16'h0102, 16'h1234);
    vt[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 8'h55, 1'b0, 16'h1234, 16'h1235);
    vt[13] = mk(1'b1, 8'h76, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 8'h55, 1'b0, 16'h1234, 16'hFFFF);
    vt[14] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 8'h76, 1'b0, 16'hFFFF, 16'h0000);
    vt[15] = mk(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 16'h0200, 1'b1, 16'h0000, 1'b0, 8'h76, 1'b0, 16'hFFFF, 16'h0000);
    vt[16] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b0, 8'h76, 1'b0, 16'hFFFF, 16'h0200);

    i_rst_n = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = 8'h00; i_ready = 1'b0;
    i_dec_is_instr16 = 1'b0; i_redirect = 1'b0; i_redirect_pc = 16'h0000; i_halt_bug = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", 32'(o_instr), 32'h00);
    chk("rst_is16", 32'(o_is_instr16), 32'd0);
    chk("rst_ipc", 32'(o_instr_pc), 32'h0000);
    chk("rst_pc", 32'(o_pc), 32'h0100);
    i_rst_n = 1'b1;
    #1;

    // Cycle table: zero-wait fetches, CB prefix, stall, drain, wrap, redirect with ack.
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("t%0d_req", i), 32'(o_mem_req), 32'(vt[i].e_req));
      if (vt[i].e_req) chk($sformatf("t%0d_addr", i), 32'(o_mem_addr), 32'(vt[i].e_addr));
      chk($sformatf("t%0d_valid", i), 32'(o_valid), 32'(vt[i].e_valid));
      chk($sformatf("t%0d_instr", i), 32'(o_instr), 32'(vt[i].e_instr));
      chk($sformatf("t%0d_is16", i), 32'(o_is_instr16), 32'(vt[i].e_is16));
      chk($sformatf("t%0d_ipc", i), 32'(o_instr_pc), 32'(vt[i].e_ipc));
      chk($sformatf("t%0d_pc", i), 32'(o_pc), 32'(vt[i].e_pc));
      i_mem_ack = vt[i].ack; i_mem_rdata = vt[i].rdata; i_ready = vt[i].ready;
      i_dec_is_instr16 = vt[i].dec16; i_redirect = vt[i].redir; i_redirect_pc = vt[i].rpc;
      tick();
    end

    // Halt bug: redirect to 0x0400 (drains the pending read), pulse, then collect three bytes.
    i_mem_ack = 1'b0; i_ready = 1'b1; i_dec_is_instr16 = 1'b0;
    i_redirect = 1'b1; i_redirect_pc = 16'h0400;
    tick();
    i_redirect = 1'b0; i_halt_bug = 1'b1;
    tick();
    i_halt_bug = 1'b0; mem_auto = 1'b1; wcnt = 0; wtgt = 0;
    mem_respond();
    got = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      if (o_valid) begin
        ipcs[got] = o_instr_pc; ins[got] = o_instr; got++;
      end
      if (got < 3) tick();
    end
`ifdef SM83_HALT_BUG_EN
    exp_ipc[0] = 16'h0400; exp_ipc[1] = 16'h0400; exp_ipc[2] = 16'h0401;
`else
    exp_ipc[0] = 16'h0400; exp_ipc[1] = 16'h0401; exp_ipc[2] = 16'h0402;
`endif
    chk("halt_count", 32'(got), 32'd3);
    for (int k = 0; k < got; k++) begin
      chk($sformatf("halt_ipc%0d", k), 32'(ipcs[k]), 32'(exp_ipc[k]));
      chk($sformatf("halt_instr%0d", k), 32'(ins[k]), 32'(mem[exp_ipc[k]]));
    end

    // Stall: hold o_valid with i_ready=0 for five cycles.
    tick();
    i_ready = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && !o_valid; c++) tick();
    chk("stall_reach_valid", 32'(o_valid), 32'd1);
    h_instr = o_instr; h_ipc = o_instr_pc; h_pc = o_pc;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_req", 32'(o_mem_req), 32'd0);
      chk("stall_instr", 32'(o_instr), 32'(h_instr));
      chk("stall_ipc", 32'(o_instr_pc), 32'(h_ipc));
      chk("stall_pc", 32'(o_pc), 32'(h_pc));
    end
    i_ready = 1'b1;
    tick();

    // Randomized run: the model tracks only the expected delivered byte stream.
    rand_wait = 1'b1;
    exp_pc = 16'h0000; exp_is16 = 1'b0; ndel = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 16'h0000;
    for (int k = 0; k < 3000; k++) begin
      if (prev_req && !prev_ack && o_mem_req)
        chk("addr_hold", 32'(o_mem_addr), 32'(prev_addr));
      i_ready = ($urandom_range(3, 0) != 0);
      i_redirect = (k == 0) || ($urandom_range(15, 0) == 0);
      i_redirect_pc = 16'($urandom);
      i_dec_is_instr16 = ($urandom_range(3, 0) == 0);
      if (i_redirect) begin
        exp_pc = i_redirect_pc; exp_is16 = 1'b0;
      end else if (o_valid && i_ready) begin
        chk("rnd_ipc", 32'(o_instr_pc), 32'(exp_pc));
        chk("rnd_instr", 32'(o_instr), 32'(mem[exp_pc]));
        chk("rnd_is16", 32'(o_is_instr16), 32'(exp_is16));
        exp_pc = exp_pc + 16'd1;
        exp_is16 = i_dec_is_instr16;
        ndel++;
      end
      prev_req = o_mem_req; prev_ack = i_mem_ack; prev_addr = o_mem_addr;
      tick();
    end
    chk("rnd_progress", 32'(ndel >= 150), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
